ifetch_buffer: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current pc and issues word-aligned requests to instruction memory using a req/gnt/rvalid handshake.
- Buffers returned instructions, each paired with its pc, in a small FIFO that feeds decode.
- Drives pc_en so the next-PC path advances the PC register only when a fetch is accepted. Flush on redirect (branch/jump) discards buffered and in-flight instructions.

---
 rtl/ifetch_buffer.sv | 176 +++++++++++++++++
 tb/tb_ifetch_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction-fetch stage between the PC register and decode.
// Issues one word-aligned request at a time over a req/gnt/rvalid handshake,
// pairs each returned instruction with its pc and queues it in a small FIFO.
// Optional feature macro: IFB_ALIGN_CHECK_EN (misaligned pc produces a marker
// entry instead of a memory request).
module ifetch_buffer #(
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] pc,
  output logic         pc_en,
  input  logic         flush,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [n-1:0] imem_rdata,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [n-1:0] if_instr,
  output logic [n-1:0] if_pc,
  output logic         if_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state_reg, state_next;
  logic           drop_reg, drop_next;
  logic [n-1:0]   req_pc_reg;
  logic [CW-1:0]  count_reg;
  logic [AW-1:0]  rd_ptr_reg, wr_ptr_reg;

  logic [n-1:0]   pc_mem    [DEPTH];
  logic [n-1:0]   instr_mem [DEPTH];
`ifdef IFB_ALIGN_CHECK_EN
  logic           mis_mem   [DEPTH];
`endif

  logic           space;
  logic           grant;
  logic           push;
  logic           pop;
  logic [n-1:0]   push_pc;
  logic [n-1:0]   push_instr;
  logic           push_mis;

  assign space     = (count_reg < CW'(DEPTH));
  assign imem_addr = {pc[n-1:2], 2'b00};
  assign if_valid  = (count_reg != '0);
  assign if_pc     = pc_mem[rd_ptr_reg];
  assign if_instr  = instr_mem[rd_ptr_reg];
`ifdef IFB_ALIGN_CHECK_EN
  assign if_misalign = mis_mem[rd_ptr_reg];
`else
  assign if_misalign = 1'b0;
`endif

  // A flushed pop is dropped along with everything else in the FIFO.
  assign pop = if_valid && if_ready && !flush;

  // Next-state, handshake outputs and push selection for the fetch FSM.
  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    imem_req   = 1'b0;
    pc_en      = 1'b0;
    grant      = 1'b0;
    push       = 1'b0;
    push_pc    = req_pc_reg;
    push_instr = imem_rdata;
    push_mis   = 1'b0;
    case (state_reg)
      IDLE: begin
`ifdef IFB_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) begin
          // Misaligned pc: queue a marker entry locally, no memory traffic.
          if (!rst && !flush && space) begin
            push       = 1'b1;
            pc_en      = 1'b1;
            push_pc    = pc;
            push_instr = '0;
            push_mis   = 1'b1;
          end
        end else begin
          imem_req = !rst && !flush && space;
        end
`else
        imem_req = !rst && !flush && space;
`endif
        grant = imem_req && imem_gnt;
        if (grant) begin
          pc_en      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // Stale (flushed) responses are discarded; the slot is free again.
          push       = !drop_reg && !flush;
          drop_next  = 1'b0;
          state_next = IDLE;
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, drop flag and the pc captured at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      drop_reg   <= 1'b0;
      req_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;
      if (grant) begin
        req_pc_reg <= pc;
      end
    end
  end

  // FIFO occupancy and pointers; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; head fields are read straight from the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
`ifdef IFB_ALIGN_CHECK_EN
        mis_mem[i]   <= 1'b0;
`endif
      end
    end else if (push) begin
      pc_mem[wr_ptr_reg]    <= push_pc;
      instr_mem[wr_ptr_reg] <= push_instr;
`ifdef IFB_ALIGN_CHECK_EN
      mis_mem[wr_ptr_reg]   <= push_mis;
`endif
    end
  end

`ifndef IFB_ALIGN_CHECK_EN
  // push_mis only carries information when the alignment check is built in.
  logic unused_mis;
  assign unused_mis = push_mis;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed scenarios with literal expectations, then a
// randomized run; a queue-based fetch model is compared every cycle.
module tb_ifetch_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pc = '0;
  logic         pc_en;
  logic         flush = 1'b0;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [N-1:0] imem_rdata = '0;
  logic         if_valid;
  logic         if_ready = 1'b0;
  logic [N-1:0] if_instr;
  logic [N-1:0] if_pc;
  logic         if_misalign;

  ifetch_buffer #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  // Behavioural model: delivered-instruction queue plus one outstanding fetch.
  entry_t      exp_q[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_req_pc;
  bit          m_grant;
  int          lat;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance one clock.
  task automatic tick();
    bit misal, space, exp_req, mpush, exp_pc_en;
    entry_t e;
    #1;
`ifdef IFB_ALIGN_CHECK_EN
    misal = (pc[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    space     = (exp_q.size() < DEPTH);
    exp_req   = !rst && !flush && !m_out && space && !misal;
    mpush     = !rst && !flush && !m_out && space && misal;
    m_grant   = exp_req && imem_gnt;
    exp_pc_en = m_grant || mpush;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("pc_en", {31'b0, pc_en}, {31'b0, exp_pc_en});
    if (exp_req) chk("imem_addr", imem_addr, {pc[31:2], 2'b00});
    chk("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("if_pc", if_pc, exp_q[0].pc);
      chk("if_instr", if_instr, exp_q[0].instr);
      chk("if_misalign", {31'b0, if_misalign}, {31'b0, exp_q[0].mis});
    end
    if (rst) begin
      exp_q.delete();
      m_out   = 0;
      m_stale = 0;
    end else if (flush) begin
      exp_q.delete();
      if (m_out) begin
        if (imem_rvalid) begin
          m_out   = 0;
          m_stale = 0;
        end else begin
          m_stale = 1;
        end
      end
    end else begin
      if (exp_q.size() != 0 && if_ready) begin
        e = exp_q.pop_front();
        $display("deliver pc=%h instr=%h mis=%0d", e.pc, e.instr, e.mis);
      end
      if (m_out && imem_rvalid) begin
        if (!m_stale) exp_q.push_back('{pc: m_req_pc, instr: imem_rdata, mis: 1'b0});
        m_out   = 0;
        m_stale = 0;
      end
      if (m_grant) begin
        m_out    = 1;
        m_req_pc = pc;
      end
      if (mpush) exp_q.push_back('{pc: pc, instr: 32'h0, mis: 1'b1});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset-then-single-fetch sequence with hand-computed expectations.
  task automatic basic_fetch();
    if_ready = 0; flush = 0; pc = 32'h0; imem_gnt = 1; imem_rvalid = 0;
    #1 chk("s1_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00500093;
    #1 chk("s1_wait_req", {31'b0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 0;
    #1;
    chk("s1_valid", {31'b0, if_valid}, 32'd1);
    chk("s1_pc", if_pc, 32'h0);
    chk("s1_instr", if_instr, 32'h00500093);
    if_ready = 1;
    tick();
    if_ready = 0;
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    #1;
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_mis", {31'b0, if_misalign}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    rst = 0;

    // Single fetch, two-cycle visibility after grant.
    basic_fetch();

    // Fill to full, request suppressed, drain in order.
    pc = 32'h0; imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA0; tick();
    imem_rvalid = 0; pc = 32'h4; imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA4; tick();
    imem_rvalid = 0; imem_gnt = 1;
    #1 chk("full_req", {31'b0, imem_req}, 32'd0);
    imem_gnt = 0; if_ready = 1;
    #1 chk("full_head0", if_pc, 32'h0);
    tick();
    #1 chk("full_head1", if_pc, 32'h4);
    tick();
    if_ready = 0;
    #1 chk("drained_req", {31'b0, imem_req}, 32'd1);

    // Flush in WAIT; stale response three cycles later is discarded.
    pc = 32'h8; imem_gnt = 1; tick();
    imem_gnt = 0; flush = 1; tick();
    flush = 0; tick();
    tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD; tick();
    imem_rvalid = 0;
    #1 chk("stale_valid", {31'b0, if_valid}, 32'd0);
    pc = 32'h40; imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h13; tick();
    imem_rvalid = 0;
    #1 chk("redir_pc", if_pc, 32'h40);
    chk("redir_instr", if_instr, 32'h13);
    if_ready = 1; tick(); if_ready = 0;

    // Flush coincident with rvalid and a pop.
    pc = 32'h10; imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h11; tick();
    imem_rvalid = 0; pc = 32'h14; imem_gnt = 1; tick();
    imem_gnt = 0; flush = 1; imem_rvalid = 1; imem_rdata = 32'h15; if_ready = 1; tick();
    flush = 0; imem_rvalid = 0; if_ready = 0;
    #1 chk("fc_valid", {31'b0, if_valid}, 32'd0);
    chk("fc_idle_req", {31'b0, imem_req}, 32'd1);
    pc = 32'h18; imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h19; tick();
    imem_rvalid = 0;
    #1 chk("fc_nodrop_pc", if_pc, 32'h18);
    if_ready = 1; tick(); if_ready = 0;

    // Reset mid-WAIT.
    pc = 32'h20; imem_gnt = 1; tick();
    imem_gnt = 0; rst = 1; tick();
    #1;
    chk("rw_req", {31'b0, imem_req}, 32'd0);
    chk("rw_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rw_valid", {31'b0, if_valid}, 32'd0);
    chk("rw_instr", if_instr, 32'h0);
    chk("rw_pc", if_pc, 32'h0);
    rst = 0;
    basic_fetch();

`ifdef IFB_ALIGN_CHECK_EN
    // Misaligned pc yields a marker entry without a memory request.
    pc = 32'h6; imem_gnt = 1;
    #1 chk("mis_req", {31'b0, imem_req}, 32'd0);
    chk("mis_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    imem_gnt = 0; pc = 32'h0;
    #1;
    chk("mis_flag", {31'b0, if_misalign}, 32'd1);
    chk("mis_pc", if_pc, 32'h6);
    chk("mis_instr", if_instr, 32'h0);
    if_ready = 1; tick(); if_ready = 0;
`endif

    // Randomized run against the model; memory answers after 1..3 cycles.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom % 200) == 0;
      flush    = ($urandom % 12) == 0;
      if_ready = ($urandom % 10) < 6;
      imem_gnt = ($urandom % 10) < 7;
      pc       = $urandom;
      if (($urandom % 4) != 0) pc[1:0] = 2'b00;
      imem_rdata = $urandom;
      if (m_out) begin
        if (lat == 0) imem_rvalid = 1;
        else begin
          imem_rvalid = 0;
          lat--;
        end
      end else begin
        imem_rvalid = ($urandom % 20) == 0;
      end
      tick();
      if (m_grant && !rst) lat = $urandom_range(0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
